// File: rtl/div_32_seq.sv
// rtl/div_32_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
// Divide-by-zero completes after one cycle with quo=all ones, rem=dividend.
module div_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rp, rp_nxt;
  logic [WIDTH-1:0] qsh, qsh_nxt;
  logic [WIDTH-1:0] dvs, dvs_nxt;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             zdiv, zdiv_nxt;
  logic             done_nxt, dbz_nxt;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign trial = {1'b0, rp[WIDTH-2:0], qsh[WIDTH-1]} - {1'b0, dvs};
  // A set top bit of rp means the shifted value already exceeds any divisor.
  assign borrow = trial[WIDTH] & ~rp[WIDTH-1];

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rp_nxt    = rp;
    qsh_nxt   = qsh;
    dvs_nxt   = dvs;
    zdiv_nxt  = zdiv;
    quo_nxt   = quo;
    rem_nxt   = rem;
    dbz_nxt   = dbz;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rp_nxt    = '0;
          qsh_nxt   = a;
          dvs_nxt   = b;
          cnt_nxt   = CW'(WIDTH);
          zdiv_nxt  = (b == '0);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (zdiv) begin
          quo_nxt   = '1;
          rem_nxt   = qsh;
          dbz_nxt   = 1'b1;
          done_nxt  = 1'b1;
          zdiv_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          if (!borrow) begin
            rp_nxt  = trial[WIDTH-1:0];
            qsh_nxt = {qsh[WIDTH-2:0], 1'b1};
          end else begin
            rp_nxt  = {rp[WIDTH-2:0], qsh[WIDTH-1]};
            qsh_nxt = {qsh[WIDTH-2:0], 1'b0};
          end
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quo_nxt   = qsh_nxt;
            rem_nxt   = rp_nxt;
            dbz_nxt   = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rp   <= '0;
      qsh  <= '0;
      dvs  <= '0;
      zdiv <= 1'b0;
      quo  <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      rp   <= rp_nxt;
      qsh  <= qsh_nxt;
      dvs  <= dvs_nxt;
      zdiv <= zdiv_nxt;
      quo  <= quo_nxt;
      rem  <= rem_nxt;
      dbz  <= dbz_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// tb/tb_div_32_seq.sv - scoreboard bench for div_32_seq against an arithmetic reference
module tb_div_32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] quo, rem;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;

  div_32_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input int due);
    exp_t e;
    e.a = av;
    e.b = bv;
    e.due = due;
    if (bv == 0) begin
      e.q = '1;
      e.r = av;
      e.z = 1'b1;
    end else begin
      e.q = av / bv;
      e.r = av % bv;
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=quo 0x%0h rem 0x%0h required=no done (cycle %0d)", quo, rem, cyc);
      end else begin
        cur = sbq.pop_front();
        check("quo", quo, cur.q);
        check("rem", rem, cur.r);
        check("dbz", dbz, cur.z);
        check("latency", cyc, cur.due);
        if (!cur.z) begin
          check("identity", ({32'b0, quo} * {32'b0, cur.b}) + {32'b0, rem}, {32'b0, cur.a});
          check("rem_lt_b", rem < cur.b, 1'b1);
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=busy 1 required=0 within 200 cycles");
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_idle();
    a = av;
    b = bv;
    start = 1'b1;
    sbq.push_back(model(av, bv, cyc + 1 + ((bv == 0) ? 1 : W)));
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_start", busy, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", dbz, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2, 1);
    do_op(24, 2);
    do_op(16, 2);
    do_op(11, 5);
    do_op(32'hFFFF_FFFF, 1);
    do_op(5, 32'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'h8000_0000);
    do_op(37, 0);
    do_op(9, 3);

    do_op(100, 7);
    repeat (9) @(negedge clk);
    a = 1;
    b = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    do_op(50, 3);
    repeat (13) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quo", quo, 0);
    check("midrst_rem", rem, 0);
    check("midrst_dbz", dbz, 1'b0);
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(50, 3);
    do_op(0, 0);
    do_op(0, 13);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom | 32'h8000_0000;
      endcase
      if (rb == 0) rb = 1;
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      do_op(ra, rb);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_32_seq.md
Name: div_32_seq

Overview:
Sequential unsigned restoring divider, the inverse operation of the 32-bit adder/subtractor/multiplier datapath (fa_32).
- Accepts a dividend and a divisor on a start pulse.
- Produces one quotient bit per clock.
- Returns the quotient and remainder with a one-cycle done pulse.
- Serves as the divide unit next to fa_32 in the arithmetic block; the multiplier's pdt path can be checked against it (a*b / b == a).

Parameters:
WIDTH, 32, operand width in bits; quotient and remainder are WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when busy=0
a  input  WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; quo/rem/dbz valid from this cycle
quo  output  WIDTH  quotient
rem  output  WIDTH  remainder
dbz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset is asynchronous and active-low, applied on rst_n falling with no clock needed.
  - busy=0, done=0, quo=0, rem=0, dbz=0.
  - State returns to IDLE and the iteration counter is cleared.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - a and b are latched.
  - The partial remainder register is cleared and the quotient shift register is loaded with a.
  - The counter is loaded with WIDTH.
  - busy goes to 1 after edge k.
  - If b==0, go to the divide-by-zero path; otherwise go to RUN.
- RUN, one iteration per edge:
  - Form trial = {rem_partial[WIDTH-2:0], qsh[WIDTH-1]} minus the divisor. The subtract is WIDTH+1 bits wide so the borrow is visible.
  - If there is no borrow: rem_partial = trial, shift in quotient bit 1.
  - If there is a borrow: rem_partial = the shifted value, shift in quotient bit 0.
  - Decrement the counter.
- Completion:
  - The final iteration happens at edge k+WIDTH.
  - At that edge quo and rem are registered, done=1, busy=0, dbz=0, and state returns to IDLE.
  - Latency from the start-sampling edge to done high is exactly WIDTH cycles (32 for the default).
- Divide-by-zero:
  - At edge k+1: quo = all ones, rem = a, dbz=1, done=1, busy=0, state IDLE.
  - Latency is 1 cycle.
- done is high for exactly one cycle. quo, rem and dbz hold their values until the next completion, or until reset.
- start while busy=1 is ignored: no effect on the operation in flight, and it is not queued.
- start in the same cycle that done=1:
  - The state is already IDLE, so the request is accepted.
  - busy=1 on the following cycle and back-to-back operations have no bubble.
  - The done pulse from the previous operation is not extended.
- a and b may change freely after the start-sampling edge; only the latched copies are used.
- All arithmetic is unsigned. quo*b + rem == a and rem < b must hold for every b != 0.
- Reset mid-RUN aborts the operation: done is not asserted, and the outputs take their reset values.

Test Plan:
- Basic ratios, back-to-back with no idle cycles: a=2,b=1 -> quo=2,rem=0; a=24,b=2 -> quo=12,rem=0; a=16,b=2 -> quo=8,rem=0; a=11,b=5 -> quo=2,rem=1. Each done pulse arrives exactly 32 cycles after its start edge, and dbz=0 throughout.
- Extremes: a=0xFFFFFFFF,b=1 -> quo=0xFFFFFFFF,rem=0; a=5,b=0xFFFFFFFF -> quo=0,rem=5; a=0x80000000,b=0x80000000 -> quo=1,rem=0.
- Divide-by-zero: a=37,b=0 -> done one cycle after start, quo=0xFFFFFFFF, rem=37, dbz=1. The next normal op, a=9,b=3, gives quo=3, rem=0, dbz=0.
- Start while busy: start a=100,b=7, then pulse start with a=1,b=1 at cycle 10. Result is quo=14, rem=2 at cycle 32, and there is no second done pulse.
- Reset mid-op: start a=50,b=3, drop rst_n at cycle 15 for 2 cycles. busy, done, quo, rem and dbz clear immediately. A fresh start a=50,b=3 then gives quo=16, rem=2.
- Random self-check: 1000 random pairs with b != 0 satisfy quo*b + rem == a, rem < b, and the latency rule.
